// File: rtl/reg_write_initiator.sv
// Write initiator for single-cycle register writes: queues upstream words in a FIFO and issues each one
// as a one-cycle write strobe, then retires the word on done or drops it after a bounded wait.
module reg_write_initiator #(
    parameter int unsigned WIDTH   = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] reg_in,
    output logic             reg_write_en,
    input  logic             reg_done,
    input  logic             err_clr,
    output logic             busy,
    output logic             err,
    output logic [7:0]       wr_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TMR_W = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       wr_count_d;
    logic [WIDTH-1:0] head_d;
    logic             push, pop, set_err;

    // Next-state, FIFO bookkeeping and timer update
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        wr_count_d = wr_count;
        pop        = 1'b0;
        set_err    = 1'b0;
        push       = in_valid & in_ready;
        count_d    = count_q + CNT_W'(push);

        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = ISSUE;
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (reg_done) begin
                    pop        = 1'b1;
                    wr_count_d = wr_count + 8'd1;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    pop     = 1'b1;
                    set_err = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        if (state_q == WAIT && reg_done)
            state_d = (count_d != '0) ? ISSUE : IDLE;

        // A word pushed into a FIFO that empties this cycle is not yet in memory
        head_d = (count_q == CNT_W'(pop)) ? in_data : mem_q[rd_ptr_d];
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    // Pointers, occupancy, timer and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            reg_in       <= '0;
            reg_write_en <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            err          <= 1'b0;
            wr_count     <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            count_q      <= count_d;
            timer_q      <= timer_d;
            reg_write_en <= (state_d == ISSUE);
            if (state_d == ISSUE) reg_in <= head_d;
            in_ready     <= (count_d != CNT_W'(DEPTH));
            busy         <= (count_d != '0) | (state_d != IDLE);
            wr_count     <= wr_count_d;
            if (set_err)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: doc/reg_write_initiator.md
Name: reg_write_initiator

Overview:
- Initiator side of the single-cycle register write protocol (in / write_en -> out / done).
- Accepts data words from an upstream valid/ready source into a small FIFO.
- Issues each word as a one-cycle write_en pulse to a downstream register, waits for its done pulse, then retires the word.
- Sits between datapath producers and Calyx-style std_reg instances; supervises write completion with a timeout and sticky error.

Parameters:
- WIDTH, 2, data width of queued words and of reg_in.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- TIMEOUT, 15, max cycles spent in WAIT without reg_done before abort; 1..255.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  input  WIDTH  upstream data word.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  FIFO can accept a word this cycle.
- reg_in  output  WIDTH  data to downstream register.
- reg_write_en  output  1  one-cycle write strobe to downstream register.
- reg_done  input  1  downstream register done pulse.
- err_clr  input  1  clears sticky err.
- busy  output  1  FIFO non-empty or FSM not IDLE.
- err  output  1  sticky: a write timed out.
- wr_count  output  8  completed writes, modulo 256.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - FSM to IDLE, FIFO empty, timer=0.
  - reg_in=0, reg_write_en=0, err=0, wr_count=0.
  - in_ready=1 and busy=0 on the first cycle after release.
- Reset asserted mid-transaction discards all queued words and any pending write; no done is awaited afterwards.
- Push: occurs when in_valid & in_ready. in_ready = !full, computed from registered occupancy only.
  - When full, a push is refused even if a pop happens in the same cycle.
- Push and pop in the same cycle: occupancy unchanged; pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: FIFO non-empty -> ISSUE next cycle; otherwise stay.
  - ISSUE: reg_write_en=1 for exactly this cycle. reg_in is loaded from the FIFO head at the clock edge entering ISSUE and held until the next ISSUE. Clear timer. -> WAIT.
  - WAIT, reg_done=1: pop head and increment wr_count (255 wraps to 0).
    - If occupancy after pop > 0 (including a same-cycle push) -> ISSUE.
    - Otherwise -> IDLE.
  - WAIT, reg_done=0, timer==TIMEOUT-1: pop (drop) head, set err, wr_count unchanged, -> IDLE.
  - WAIT otherwise: timer+1.
- reg_done is ignored in IDLE and ISSUE, including a done arriving in the same cycle as write_en.
- err: set by timeout, cleared by err_clr. Set and clear in the same cycle: set wins.
- Latency, word pushed into an empty FIFO at edge t:
  - IDLE sees it in cycle t -> ISSUE (write_en high) in cycle t+1.
  - Earliest legal done in cycle t+2, pop at the end of t+2.
  - wr_count updated in cycle t+3.
- Steady-state throughput is one write per 2 cycles when the register returns done 1 cycle after write_en.
- reg_write_en and reg_in are glitch-free: decoded from registered state and register outputs only.
- busy = (occupancy != 0) | (state != IDLE).

Test Plan:
- Reset mid-WAIT: 2 words queued, reset=0 pulsed during WAIT -> err=0, wr_count=0, in_ready=1, reg_write_en=0, busy=0. No further strobes after release.
- Single write: push 2'b10 into empty FIFO, register responds with done 1 cycle after write_en -> write_en high exactly 1 cycle, 1 cycle after the push edge, with reg_in=2'b10. wr_count=1. busy low 1 cycle after done.
- Back-to-back fill: push 4 words {1,2,3,0}, 5th word presented while full -> in_ready=0 and the 5th is not accepted until the first pop.
  - Strobes carry 1,2,3,0 in order, spaced 2 cycles apart; wr_count=4.
- Timeout: TIMEOUT=15, never return done -> err=1 after 15 WAIT cycles. Word dropped, wr_count unchanged, next queued word issued afterwards.
  - Assert err_clr in the same cycle as a second timeout -> err stays 1.
- Spurious done: reg_done high in IDLE and in the ISSUE cycle -> no pop and no wr_count change.
  - Done 3 cycles later in WAIT retires the word.
- Counter wrap: 256 completed writes -> wr_count reads 0. Push/pop in the same cycle at occupancy 2 keeps occupancy 2.
